neuron_step_sequencer: RTL and testbench

Time-multiplexing controller for the neuron `core` pipeline. It owns the v/w state of `N_NEURONS` neurons and, per timestep, streams each neuron's state and input current into the core. It writes the core results back into state storage and emits spike events through a valid/ready FIFO. It sits directly upstream of the core, feeding its `i`/`v`/`w_in`, and directly downstream of it, consuming its `v_out`/`w_out`.

---
 rtl/neuron_step_sequencer_pkg.sv | 16 +
 rtl/neuron_step_sequencer_if.sv | 15 +
 rtl/neuron_step_sequencer_spike_fifo.sv | 35 +++
 rtl/neuron_step_sequencer.sv | 110 +++++++++++
 tb/tb_neuron_step_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_step_sequencer_pkg.sv
// neuron_step_sequencer_pkg: shared Q-format widths, reset constants, FSM state and tag types.
// No ports; imported by the sequencer, its interface and the testbench.
package neuron_step_sequencer_pkg;
  localparam int INT_WIDTH = 3;
  localparam int FRC_WIDTH = 12;
  localparam int W = 1 + INT_WIDTH + FRC_WIDTH;
  localparam int IDX_W = 8;
  localparam logic signed [W-1:0] V_RST = 16'hECE1;
  localparam logic signed [W-1:0] W_RST = 16'hF600;
  typedef enum logic [1:0] {INIT, IDLE, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic valid;
    logic [IDX_W-1:0] idx;
    logic signed [W-1:0] v_old;
  } tag_t;
endpackage

// File: rtl/neuron_step_sequencer_if.sv
// neuron_step_sequencer_if: core data bus and spike event stream.
// master (sequencer): drives core_i/core_v/core_w, spk_valid/spk_id; receives core_v_out/core_w_out, spk_ready.
// slave (core + spike consumer): the opposite directions.
interface neuron_step_sequencer_if import neuron_step_sequencer_pkg::*; #(
  parameter int N_NEURONS = 16
);
  localparam int IW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1;
  logic signed [W-1:0] core_i, core_v, core_w, core_v_out, core_w_out;
  logic spk_valid, spk_ready;
  logic [IW-1:0] spk_id;
  modport master(output core_i, core_v, core_w, spk_valid, spk_id,
                 input core_v_out, core_w_out, spk_ready);
  modport slave(input core_i, core_v, core_w, spk_valid, spk_id,
                output core_v_out, core_w_out, spk_ready);
endinterface

// File: rtl/neuron_step_sequencer_spike_fifo.sv
// spike_fifo: synchronous FIFO; a push while full is accepted when a pop happens the same cycle.
// Ports: clk, rst_n (async low), push/din, pop/dout (0 when empty), full, empty.
module spike_fifo #(
  parameter int DEPTH = 8,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      wr <= wr + (AW+1)'(do_push);
      rd <= rd + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/neuron_step_sequencer.sv
// neuron_step_sequencer: time-multiplexes N neuron states through an external core, one timestep per step_start.
// Ports: clk, rst_n (async low); step_start/step_busy/step_done/t_step step control;
// cur_idx/cur_in current fetch; spk_drop sticky overflow flag; bus (master) core data + spike stream.
// Optional: define SPIKE_COUNT_EN to add spk_count, spikes detected in the last completed step.
module neuron_step_sequencer import neuron_step_sequencer_pkg::*; #(
  parameter int N_NEURONS = 16,
  parameter int CORE_LAT = 4,
  parameter logic signed [W-1:0] SPIKE_TH = 16'sd4096,
  parameter int FIFO_DEPTH = 8,
  localparam int IW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_start,
  output logic                step_busy,
  output logic                step_done,
  output logic [15:0]         t_step,
  output logic [IW-1:0]       cur_idx,
  input  logic signed [W-1:0] cur_in,
  output logic                spk_drop,
`ifdef SPIKE_COUNT_EN
  output logic [$clog2(N_NEURONS+1)-1:0] spk_count,
`endif
  neuron_step_sequencer_if.master bus
);
  state_t state, state_nx;
  logic [IW-1:0] cnt, wb_idx;
  logic signed [W-1:0] v_mem [N_NEURONS];
  logic signed [W-1:0] w_mem [N_NEURONS];
  tag_t pipe [CORE_LAT+1];
  tag_t tail, new_tag;
  logic launch, last_cnt, spike, drain_last, pop, fifo_full, fifo_empty;
  assign last_cnt = cnt == IW'(N_NEURONS-1);
  assign tail = pipe[CORE_LAT];
  assign wb_idx = tail.idx[IW-1:0];
  assign new_tag = '{valid: launch, idx: IDX_W'(cur_idx), v_old: v_mem[cur_idx]};
  assign spike = tail.valid && $signed(tail.v_old) < $signed(SPIKE_TH)
                 && $signed(bus.core_v_out) >= $signed(SPIKE_TH);
  // The last launched neuron reaching the tail ends DRAIN.
  assign drain_last = state == DRAIN && tail.valid && tail.idx == IDX_W'(N_NEURONS-1);
  assign pop = bus.spk_valid & bus.spk_ready;
  assign bus.spk_valid = ~fifo_empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      INIT:    state_nx = last_cnt ? IDLE : INIT;
      IDLE:    state_nx = step_start ? (N_NEURONS == 1 ? DRAIN : ISSUE) : IDLE;
      ISSUE:   state_nx = last_cnt ? DRAIN : ISSUE;
      DRAIN:   state_nx = drain_last ? IDLE : DRAIN;
      default: state_nx = INIT;
    endcase
  end
  // Neuron 0 launches on the IDLE edge that samples step_start; ISSUE covers 1..N-1.
  always_comb begin
    step_busy = state != IDLE;
    launch = state == ISSUE || (state == IDLE && step_start);
    cur_idx = state == ISSUE ? cnt : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      step_done <= 1'b0;
      t_step <= '0;
      spk_drop <= 1'b0;
      bus.core_i <= '0;
      bus.core_v <= V_RST;
      bus.core_w <= W_RST;
      for (int i = 0; i <= CORE_LAT; i++) pipe[i] <= '0;
    end else begin
      cnt <= (state == INIT || state == ISSUE) ? (last_cnt ? '0 : cnt + 1'b1) : (launch ? IW'(1) : '0);
      step_done <= drain_last;
      t_step <= t_step + 16'(drain_last);
      spk_drop <= spk_drop | (spike & fifo_full & ~pop);
      if (launch) begin
        bus.core_i <= cur_in;
        bus.core_v <= v_mem[cur_idx];
        bus.core_w <= w_mem[cur_idx];
      end
      pipe[0] <= new_tag;
      for (int i = 1; i <= CORE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  always_ff @(posedge clk)
    if (state == INIT) begin
      v_mem[cnt] <= V_RST;
      w_mem[cnt] <= W_RST;
    end else if (tail.valid) begin
      v_mem[wb_idx] <= bus.core_v_out;
      w_mem[wb_idx] <= bus.core_w_out;
    end
  spike_fifo #(.DEPTH(FIFO_DEPTH), .DW(IW)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(spike), .pop(pop), .din(wb_idx),
    .dout(bus.spk_id), .full(fifo_full), .empty(fifo_empty)
  );
`ifdef SPIKE_COUNT_EN
  localparam int CW = $clog2(N_NEURONS+1);
  logic [CW-1:0] spk_acc;
  // The final write-back shares the step_done edge, so its spike is folded in directly.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      spk_acc <= '0;
      spk_count <= '0;
    end else begin
      spk_acc <= drain_last ? '0 : spk_acc + CW'(spike);
      if (drain_last) spk_count <= spk_acc + CW'(spike);
    end
`endif
endmodule

// File: tb/tb_neuron_step_sequencer.sv
// tb_neuron_step_sequencer: scoreboard bench with a stub core (v_out=v+i, w_out=w-i, CORE_LAT stages).
module tb_neuron_step_sequencer;
  import neuron_step_sequencer_pkg::*;
  localparam int N = 16, CL = 4, FD = 8;
  localparam logic signed [15:0] TH = 16'sd4096;
  logic clk = 1'b0, rst_n, step_start, step_busy, step_done, spk_drop;
  logic [15:0] t_step;
  logic [3:0] cur_idx;
  logic signed [15:0] cur_in;
  logic signed [15:0] cur_tab [N];
  logic signed [15:0] mv [N];
  logic signed [15:0] mw [N];
  logic signed [15:0] sv [CL];
  logic signed [15:0] sw [CL];
  logic signed [15:0] si [CL];
  logic exp_drop;
  int exp_q [$];
  int n_chk = 0, n_bad = 0, n_seen = 0;
`ifdef SPIKE_COUNT_EN
  logic [$clog2(N+1)-1:0] spk_count;
`endif
  neuron_step_sequencer_if #(.N_NEURONS(N)) bus ();
  neuron_step_sequencer #(.N_NEURONS(N), .CORE_LAT(CL), .SPIKE_TH(TH), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .step_start(step_start), .step_busy(step_busy),
    .step_done(step_done), .t_step(t_step), .cur_idx(cur_idx), .cur_in(cur_in),
    .spk_drop(spk_drop),
`ifdef SPIKE_COUNT_EN
    .spk_count(spk_count),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign cur_in = cur_tab[cur_idx];
  always @(posedge clk) begin
    sv[0] <= bus.core_v;
    sw[0] <= bus.core_w;
    si[0] <= bus.core_i;
    for (int i = 1; i < CL; i++) begin
      sv[i] <= sv[i-1];
      sw[i] <= sw[i-1];
      si[i] <= si[i-1];
    end
  end
  assign bus.core_v_out = sv[CL-1] + si[CL-1];
  assign bus.core_w_out = sw[CL-1] - si[CL-1];
  always begin
    @(negedge clk);
    #1;
    if (rst_n && bus.spk_valid && bus.spk_ready) begin
      n_chk++;
      n_seen++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL spk_unexpected got=%0d exp=none", bus.spk_id);
      end else begin
        if (int'(bus.spk_id) !== exp_q[0]) begin
          n_bad++;
          $display("FAIL spk_id got=%0d exp=%0d", bus.spk_id, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end
  task automatic model_reset;
    for (int k = 0; k < N; k++) begin
      mv[k] = V_RST;
      mw[k] = W_RST;
    end
    exp_q.delete();
    exp_drop = 1'b0;
  endtask
  task automatic wait_init;
    int j = 0;
    while (step_busy && j < 40) begin
      @(negedge clk);
      j++;
      step_start = j == 15;
    end
    step_start = 1'b0;
    n_chk++;
    if (j != N) begin n_bad++; $display("FAIL init_len got=%0d exp=%0d", j, N); end
    @(negedge clk);
    n_chk++;
    if (step_busy !== 1'b0) begin n_bad++; $display("FAIL start_in_init got=%b exp=0", step_busy); end
  endtask
  task automatic wait_drain;
    int j = 0;
    while ((exp_q.size() != 0 || bus.spk_valid) && j < 60) begin
      @(negedge clk);
      j++;
    end
    n_chk++;
    if (exp_q.size() != 0 || bus.spk_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
  endtask
  task automatic run_step(input int xa, input int xb);
    logic signed [15:0] ov [N];
    logic signed [15:0] ow [N];
    logic signed [15:0] nv;
    logic [15:0] t0;
    int j, nsp;
    nsp = 0;
    for (int k = 0; k < N; k++) begin
      ov[k] = mv[k];
      ow[k] = mw[k];
      nv = mv[k] + cur_tab[k];
      if (ov[k] < TH && nv >= TH) begin
        nsp++;
        if (bus.spk_ready || exp_q.size() < FD) exp_q.push_back(k);
        else exp_drop = 1'b1;
      end
      mv[k] = nv;
      mw[k] = mw[k] - cur_tab[k];
    end
    t0 = t_step;
    @(negedge clk);
    n_chk++;
    if (step_busy !== 1'b0 || cur_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL idle busy=%b idx=%0d exp=0,0", step_busy, cur_idx);
    end
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    j = 0;
    while (!step_done && j < 60) begin
      n_chk++;
      if (j < N) begin
        if (bus.core_v !== ov[j] || bus.core_w !== ow[j] || bus.core_i !== cur_tab[j]) begin
          n_bad++;
          $display("FAIL launch%0d got=%h/%h/%h exp=%h/%h/%h", j, bus.core_v, bus.core_w, bus.core_i, ov[j], ow[j], cur_tab[j]);
        end
      end else if (bus.core_v !== ov[N-1] || bus.core_w !== ow[N-1]) begin
        n_bad++;
        $display("FAIL core_hold got=%h/%h exp=%h/%h", bus.core_v, bus.core_w, ov[N-1], ow[N-1]);
      end
      n_chk++;
      if (cur_idx !== (j < N-1 ? 4'(j+1) : 4'd0) || step_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL cur_idx@%0d got=%0d busy=%b exp=%0d", j, cur_idx, step_busy, j < N-1 ? j+1 : 0);
      end
      @(negedge clk);
      j++;
      step_start = j == xa || j == xb;
    end
    step_start = 1'b0;
    n_chk++;
    if (j != N+CL) begin n_bad++; $display("FAIL done_lat got=%0d exp=%0d", j, N+CL); end
    n_chk++;
    if (step_busy !== 1'b0 || t_step !== t0 + 16'd1) begin
      n_bad++;
      $display("FAIL step_end busy=%b t_step=%0d exp=0,%0d", step_busy, t_step, t0 + 16'd1);
    end
`ifdef SPIKE_COUNT_EN
    n_chk++;
    if (int'(spk_count) !== nsp) begin n_bad++; $display("FAIL spk_count got=%0d exp=%0d", spk_count, nsp); end
`endif
    @(negedge clk);
    n_chk++;
    if (step_done !== 1'b0 || step_busy !== 1'b0 || spk_drop !== exp_drop) begin
      n_bad++;
      $display("FAIL post_step done=%b busy=%b drop=%b exp=0,0,%b", step_done, step_busy, spk_drop, exp_drop);
    end
  endtask
  task automatic test_reset;
    step_start = 1'b0;
    bus.spk_ready = 1'b1;
    for (int k = 0; k < N; k++) cur_tab[k] = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (step_busy !== 1'b1 || step_done !== 1'b0 || t_step !== 16'd0 || cur_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_ctrl got=%b%b/%0d/%0d exp=10/0/0", step_busy, step_done, t_step, cur_idx);
    end
    n_chk++;
    if (bus.core_i !== 16'h0 || bus.core_v !== 16'hECE1 || bus.core_w !== 16'hF600) begin
      n_bad++;
      $display("FAIL rst_core got=%h/%h/%h exp=0000/ece1/f600", bus.core_i, bus.core_v, bus.core_w);
    end
    n_chk++;
    if (bus.spk_valid !== 1'b0 || bus.spk_id !== 4'd0 || spk_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_spk got=%b/%0d/%b exp=0/0/0", bus.spk_valid, bus.spk_id, spk_drop);
    end
    rst_n = 1'b1;
    wait_init();
  endtask
  task automatic test_identity;
    int s0;
    s0 = n_seen;
    for (int k = 0; k < N; k++) cur_tab[k] = '0;
    run_step(0, 0);
    wait_drain();
    n_chk++;
    if (n_seen != s0) begin n_bad++; $display("FAIL identity_spikes got=%0d exp=0", n_seen - s0); end
  endtask
  task automatic test_increment;
    for (int k = 0; k < N; k++) cur_tab[k] = 16'sh0400;
    repeat (3) run_step(0, 0);
    wait_drain();
  endtask
  task automatic test_single_spike;
    int s0;
    for (int k = 0; k < N; k++) cur_tab[k] = '0;
    cur_tab[2] = 16'sh0FFF - mv[2];
    run_step(0, 0);
    s0 = n_seen;
    cur_tab[2] = 16'sh0001;
    run_step(0, 0);
    wait_drain();
    n_chk++;
    if (n_seen - s0 != 1) begin n_bad++; $display("FAIL cross_count got=%0d exp=1", n_seen - s0); end
    s0 = n_seen;
    cur_tab[2] = '0;
    run_step(0, 0);
    wait_drain();
    n_chk++;
    if (n_seen != s0) begin n_bad++; $display("FAIL hold_count got=%0d exp=0", n_seen - s0); end
  endtask
  task automatic test_fifo_full;
    for (int k = 0; k < N; k++) cur_tab[k] = -mv[k];
    run_step(0, 0);
    wait_drain();
    for (int k = 0; k < N; k++) cur_tab[k] = 16'sh1000;
    bus.spk_ready = 1'b0;
    run_step(0, 0);
    n_chk++;
    if (bus.spk_valid !== 1'b1 || bus.spk_id !== 4'd0 || spk_drop !== 1'b1 || exp_q.size() != FD) begin
      n_bad++;
      $display("FAIL fifo_full got=%b/%0d/%b q=%0d exp=1/0/1 q=%0d", bus.spk_valid, bus.spk_id, spk_drop, exp_q.size(), FD);
    end
    bus.spk_ready = 1'b1;
    wait_drain();
  endtask
  task automatic test_start_ignored;
    for (int k = 0; k < N; k++) cur_tab[k] = 16'sh0010;
    run_step(5, 18);
    repeat (3) @(negedge clk);
    n_chk++;
    if (step_busy !== 1'b0) begin n_bad++; $display("FAIL start_ignored busy=%b exp=0", step_busy); end
    wait_drain();
  endtask
  task automatic test_reset_mid;
    for (int k = 0; k < N; k++) cur_tab[k] = 16'sh0100;
    @(negedge clk);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (step_busy !== 1'b1 || step_done !== 1'b0 || t_step !== 16'd0 || cur_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_rst_ctrl got=%b%b/%0d/%0d exp=10/0/0", step_busy, step_done, t_step, cur_idx);
    end
    n_chk++;
    if (bus.core_v !== 16'hECE1 || bus.core_w !== 16'hF600 || bus.core_i !== 16'h0 || bus.spk_valid !== 1'b0 || spk_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst_state got=%h/%h/%h/%b/%b exp=ece1/f600/0000/0/0", bus.core_v, bus.core_w, bus.core_i, bus.spk_valid, spk_drop);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    run_step(0, 0);
    wait_drain();
  endtask
  task automatic test_random;
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < N; k++) cur_tab[k] = 16'(int'($urandom_range(0, 16'h2000)) - 16'h0800);
      run_step(0, 0);
    end
    wait_drain();
  endtask
  initial begin
    test_reset();
    test_identity();
    test_increment();
    test_single_spike();
    test_fifo_full();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
